// File: rtl/booth_multiplier_4bit.sv
`timescale 1ns/1ps
// four_bit_adder_subtractor: 4-bit ripple add/subtract, Cout is the raw carry out of bit 3.
// Latency: combinational.
// Backpressure: none.
module four_bit_adder_subtractor (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       subtract,
   output logic [3:0] Result,
   output logic       Cout
);
   logic [3:0] b_eff;
   logic [4:0] sum;

   assign b_eff  = B ^ {4{subtract}};
   assign sum    = {1'b0, A} + {1'b0, b_eff} + {4'b0000, subtract};
   assign Result = sum[3:0];
   assign Cout   = sum[4];
endmodule

// booth_multiplier_4bit: sequential radix-2 Booth multiply of two signed 4-bit operands.
// Latency: start accepted at edge k, product and done after edge k+4.
// Backpressure: start ignored while busy; one operation in flight.
module booth_multiplier_4bit (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] multiplicand,
   input  logic [3:0] multiplier,
   output logic [7:0] product,
   output logic       busy,
   output logic       done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state;
   logic [3:0] acc;
   logic [3:0] q;
   logic [3:0] m;
   logic       q_m1;
   logic [2:0] count;

   logic       sub;
   logic [3:0] addsub_res;
   logic       addsub_cout;
   logic [3:0] r;
   logic       s;
   logic [3:0] acc_next;
   logic [3:0] q_next;

   assign sub = q[0] & ~q_m1;

   four_bit_adder_subtractor u_addsub (
      .A        (acc),
      .B        (m),
      .subtract (sub),
      .Result   (addsub_res),
      .Cout     (addsub_cout)
   );

   // s is the sign of the 5-bit intermediate, so acc - (-8) = +8 still shifts correctly
   always_comb begin
      r = acc;
      s = acc[3];
      case ({q[0], q_m1})
         2'b01: begin
            r = addsub_res;
            s = acc[3] ^ m[3] ^ addsub_cout;
         end
         2'b10: begin
            r = addsub_res;
            s = acc[3] ^ ~m[3] ^ addsub_cout;
         end
         default: begin
            r = acc;
            s = acc[3];
         end
      endcase
      acc_next = {s, r[3:1]};
      q_next   = {r[0], q[3:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         acc     <= 4'h0;
         q       <= 4'h0;
         m       <= 4'h0;
         q_m1    <= 1'b0;
         count   <= 3'd0;
         product <= 8'h00;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  m     <= multiplicand;
                  q     <= multiplier;
                  acc   <= 4'h0;
                  q_m1  <= 1'b0;
                  count <= 3'd4;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               acc   <= acc_next;
               q     <= q_next;
               q_m1  <= q[0];
               count <= count - 3'd1;
               if (count == 3'd1) begin
                  product <= {acc_next, q_next};
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_booth_multiplier_4bit.sv
`timescale 1ns/1ps
// Directed bench for booth_multiplier_4bit: exhaustive products, boundaries, handshake,
// ignored mid-run start, back-to-back operation and reset abort.
module tb_booth_multiplier_4bit;
   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] multiplicand;
   logic [3:0] multiplier;
   logic [7:0] product;
   logic       busy;
   logic       done;

   int tests = 0;
   int fails = 0;

   booth_multiplier_4bit dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pulse start for one cycle, wait (bounded) for done, then check the product.
   task automatic run_mult(input string tag, input logic [3:0] mi, input logic [3:0] qi,
                           input logic [7:0] exp);
      logic seen;
      seen = 1'b0;
      multiplicand = mi;
      multiplier   = qi;
      start        = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j < 10 && !seen; j++) begin
         tick();
         if (done) seen = 1'b1;
      end
      if (!seen) check({tag, "_done_timeout"}, {7'b0, seen}, 8'h01);
      check(tag, product, exp);
   endtask

   initial begin
      int busy_cnt;
      int done_cnt;
      logic [3:0] mi;
      logic [3:0] qi;
      int ex;

      reset        = 1'b1;
      start        = 1'b0;
      multiplicand = 4'h0;
      multiplier   = 4'h0;
      tick();
      tick();
      check("rst_product", product, 8'h00);
      check("rst_busy", {7'b0, busy}, 8'h00);
      check("rst_done", {7'b0, done}, 8'h00);
      reset = 1'b0;
      tick();

      // Hand-computed examples and boundaries
      run_mult("3x5", 4'd3, 4'd5, 8'h0F);
      run_mult("7x7", 4'd7, 4'd7, 8'h31);
      run_mult("0xm8", 4'd0, 4'h8, 8'h00);
      run_mult("m8xm8", 4'h8, 4'h8, 8'h40);
      run_mult("m8x7", 4'h8, 4'd7, 8'hC8);
      run_mult("7xm1", 4'd7, 4'hF, 8'hF9);
      run_mult("m1xm8", 4'hF, 4'h8, 8'h08);

      // Exhaustive sweep against signed multiplication
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 16; k++) begin
            mi = i[3:0];
            qi = k[3:0];
            ex = $signed(mi) * $signed(qi);
            run_mult("sweep", mi, qi, ex[7:0]);
         end
      end

      // Handshake: start pulsed once, observe edges k..k+5
      tick();
      multiplicand = 4'd3;
      multiplier   = 4'd5;
      start        = 1'b1;
      tick();
      start    = 1'b0;
      check("hs_busy_k", {7'b0, busy}, 8'h01);
      busy_cnt = busy ? 1 : 0;
      done_cnt = done ? 1 : 0;
      for (int j = 1; j <= 5; j++) begin
         tick();
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (j == 4) begin
            check("hs_done_k4", {7'b0, done}, 8'h01);
            check("hs_busy_k4", {7'b0, busy}, 8'h00);
            check("hs_product_k4", product, 8'h0F);
         end
         if (j == 5) begin
            check("hs_done_k5", {7'b0, done}, 8'h00);
            check("hs_product_k5", product, 8'h0F);
         end
      end
      check("hs_busy_cycles", busy_cnt[7:0], 8'd4);
      check("hs_done_cycles", done_cnt[7:0], 8'd1);
      multiplicand = 4'd7;
      multiplier   = 4'd2;
      tick();
      tick();
      check("hs_product_held", product, 8'h0F);

      // start during RUN with other operands is ignored
      multiplicand = 4'd3;
      multiplier   = 4'd5;
      start        = 1'b1;
      tick();
      start = 1'b0;
      tick();
      multiplicand = 4'hE;
      multiplier   = 4'd6;
      start        = 1'b1;
      tick();
      tick();
      start = 1'b0;
      tick();
      check("midrun_done", {7'b0, done}, 8'h01);
      check("midrun_product", product, 8'h0F);
      tick();
      check("midrun_no_restart", {7'b0, busy}, 8'h00);

      // Back-to-back with start held high: 2x3 then -4x5
      tick();
      multiplicand = 4'd2;
      multiplier   = 4'd3;
      start        = 1'b1;
      tick();
      tick();
      tick();
      tick();
      tick();
      check("b2b_done1", {7'b0, done}, 8'h01);
      check("b2b_product1", product, 8'h06);
      multiplicand = 4'hC;
      multiplier   = 4'd5;
      done_cnt = 0;
      for (int j = 1; j <= 4; j++) begin
         tick();
         if (done) done_cnt++;
      end
      check("b2b_gap_no_done", done_cnt[7:0], 8'd0);
      tick();
      start = 1'b0;
      check("b2b_done2", {7'b0, done}, 8'h01);
      check("b2b_product2", product, 8'hEC);
      tick();
      tick();

      // Reset during the second iteration aborts with no done pulse
      multiplicand = 4'd5;
      multiplier   = 4'hD;
      start        = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2 reset = 1'b1;
      #1;
      check("abort_product", product, 8'h00);
      check("abort_busy", {7'b0, busy}, 8'h00);
      check("abort_done", {7'b0, done}, 8'h00);
      tick();
      reset = 1'b0;
      done_cnt = 0;
      for (int j = 0; j < 6; j++) begin
         tick();
         if (done) done_cnt++;
      end
      check("abort_no_done", done_cnt[7:0], 8'd0);
      run_mult("after_abort_5xm3", 4'd5, 4'hD, 8'hF1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
